change_dispense_ctrl: RTL and testbench
=======================================

# change_dispense_ctrl

Sequencer that drives the coin parser and the coin ejector in the change-return path. On a start request it latches the change amount, presents it to the parser, and waits out the parser latency. It then pulses the parser enable, captures the quarter/dime/nickel counts, and dispenses coins one at a time over a req/ack handshake: all quarters, then dimes, then nickels. It sits between the vending FSM (start/done) and the parser/ejector pair.

## Interface
- PARSE_LAT, default 3: cycles from `money` stable to valid parser divider outputs.
- MAX_CHANGE, default 70: largest legal change amount in cents.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- change  in  7  change amount in cents, sampled with start
- money  out  7  amount driven to parser `money`; held for the whole transaction
- parse_en  out  1  one-cycle pulse to parser `en`
- q_cnt, d_cnt, n_cnt  in  4 each  parser Q/D/N outputs; 4'd10 means blank or invalid
- eject_q, eject_d, eject_n  out  1 each  coin request, level, held until ack
- eject_ack  in  1  ejector accepted the current coin
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of transaction, success or error
- err  out  1  sticky; set on a rejected request, cleared on the next accepted start or reset

## Operation
- States: IDLE, WAIT, LOAD, CAPT, DISP_Q, DISP_D, DISP_N, FIN.
- IDLE: on start=1:
  - latch change into `money`, clear err.
  - If change%5≠0 or change>MAX_CHANGE: set err, go to FIN. No parse_en is issued.
  - Otherwise load the wait counter with PARSE_LAT-1 and go to WAIT.
- WAIT: decrement the counter; at 0 go to LOAD.
- LOAD: parse_en=1 for exactly this cycle; go to CAPT.
- CAPT: sample q_cnt/d_cnt/n_cnt into internal remaining counters.
  - If any count >9: set err, go to FIN.
  - Otherwise go to DISP_Q.
- DISP_x (x = Q, D, N in that order):
  - Remaining=0: advance to the next DISP state, or to FIN after N. The skip takes one cycle per state.
  - Remaining>0: eject_x=1 and held.
  - A cycle with eject_x=1 and eject_ack=1 counts one coin. Remaining decrements and eject_x drops for the next cycle (mandatory 1-cycle gap).
  - eject_ack while no eject_x is high is ignored.
- FIN: done=1 for one cycle; go to IDLE. `money` keeps its last value until the next accepted start.
- At most one eject_* is high at any time.
- start while busy is ignored; no queueing.
- Arithmetic: remaining counters are 4 bits and never underflow (decrement only when >0). The change%5 check is on the full 7-bit value.

## Timing
- Reset values: money=0, parse_en=0, all eject_*=0, busy=0, done=0, err=0, state IDLE.
- Cycle numbering: start sampled at edge 0. busy=1 from cycle 1, and money is valid from cycle 1.
- The pipeline for a legal request:
  - WAIT spans cycles 1..PARSE_LAT.
  - parse_en is high in cycle PARSE_LAT+1.
  - CAPT is in cycle PARSE_LAT+2; counts sampled at the end of it.
  - First eject request is in cycle PARSE_LAT+3 if q_cnt>0.
- Best case 2 cycles per coin (request + ack same cycle, then gap).
- Illegal amount: err and busy high from cycle 1 (FIN). done pulses in cycle 1; busy=0 in cycle 2.
- Zero change: after CAPT, 3 skip cycles, then FIN. No eject_* asserted.
- Reset mid-transaction, in any state: next cycle is IDLE with all reset values. Coins already acked are not replayed.
- done and err are both observable in the FIN cycle for rejected requests.

## Test plan
- change=65, PARSE_LAT=3, ack asserted on first request cycle → parse_en in cycle 4, then eject requests in order Q,Q,D,N, each 1 cycle high with a 1-cycle gap. done pulses once, err=0.
- change=0 → parse_en pulses once, no eject_* ever high, done pulses, err=0.
- change=37, then change=75 in a separate transaction → each: no parse_en, err=1, done in cycle 1. err stays set after done and clears on the next legal start.
- change=70 with eject_ack delayed 5 cycles per coin → eject_q held steady through each delay. Exactly 2 Q + 2 D coins counted; start pulses during dispense are ignored.
- Reset asserted while eject_d=1 during change=35 → next cycle all outputs at reset values. A following change=5 completes with a single eject_n.
- Parser returns q_cnt=10 (blank) at CAPT → err=1, done pulses, no eject_* asserted.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
// Change-return sequencer: latches the amount, drives the coin parser, then
// ejects quarters, dimes and nickels one at a time over a req/ack handshake.
module change_dispense_ctrl #(
   parameter int PARSE_LAT  = 3,
   parameter int MAX_CHANGE = 70
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] change,
   output logic [6:0] money,
   output logic       parse_en,
   input  logic [3:0] q_cnt,
   input  logic [3:0] d_cnt,
   input  logic [3:0] n_cnt,
   output logic       eject_q,
   output logic       eject_d,
   output logic       eject_n,
   input  logic       eject_ack,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_CAPT   = 3'd3;
   localparam logic [2:0] S_DISP_Q = 3'd4;
   localparam logic [2:0] S_DISP_D = 3'd5;
   localparam logic [2:0] S_DISP_N = 3'd6;
   localparam logic [2:0] S_FIN    = 3'd7;

   localparam int CW = (PARSE_LAT > 1) ? $clog2(PARSE_LAT) : 1;

   logic [2:0]    state;
   logic [CW-1:0] wcnt;
   logic [3:0]    rem_q, rem_d, rem_n;
   logic          gap;
   logic          bad_amt;

   assign bad_amt = ((change % 7'd5) != 7'd0) || (change > 7'(MAX_CHANGE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         wcnt  <= '0;
         rem_q <= '0;
         rem_d <= '0;
         rem_n <= '0;
         gap   <= 1'b0;
         money <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               money <= change;
               err   <= 1'b0;
               if (bad_amt) begin
                  err   <= 1'b1;
                  state <= S_FIN;
               end else begin
                  wcnt  <= CW'(PARSE_LAT - 1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: if (wcnt == '0) state <= S_LOAD;
                    else            wcnt  <= wcnt - 1'b1;
            S_LOAD: state <= S_CAPT;
            S_CAPT: begin
               if (q_cnt > 4'd9 || d_cnt > 4'd9 || n_cnt > 4'd9) begin
                  err   <= 1'b1;
                  state <= S_FIN;
               end else begin
                  rem_q <= q_cnt;
                  rem_d <= d_cnt;
                  rem_n <= n_cnt;
                  gap   <= 1'b0;
                  state <= S_DISP_Q;
               end
            end
            // gap forces the one idle cycle between an accepted coin and the next request
            S_DISP_Q: begin
               if (rem_q == 4'd0) begin gap <= 1'b0; state <= S_DISP_D; end
               else if (gap)        gap <= 1'b0;
               else if (eject_ack) begin rem_q <= rem_q - 4'd1; gap <= 1'b1; end
            end
            S_DISP_D: begin
               if (rem_d == 4'd0) begin gap <= 1'b0; state <= S_DISP_N; end
               else if (gap)        gap <= 1'b0;
               else if (eject_ack) begin rem_d <= rem_d - 4'd1; gap <= 1'b1; end
            end
            S_DISP_N: begin
               if (rem_n == 4'd0) begin gap <= 1'b0; state <= S_FIN; end
               else if (gap)        gap <= 1'b0;
               else if (eject_ack) begin rem_n <= rem_n - 4'd1; gap <= 1'b1; end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign parse_en = (state == S_LOAD);
   assign done     = (state == S_FIN);
   assign busy     = (state != S_IDLE);
   assign eject_q  = (state == S_DISP_Q) && (rem_q != 4'd0) && !gap;
   assign eject_d  = (state == S_DISP_D) && (rem_d != 4'd0) && !gap;
   assign eject_n  = (state == S_DISP_N) && (rem_n != 4'd0) && !gap;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: per-transaction cycle monitor with
// a simple ejector model whose ack delay is set per vector.
module tb_change_dispense_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, eject_ack;
   logic [6:0] change, money;
   logic [3:0] q_cnt, d_cnt, n_cnt;
   logic       parse_en, eject_q, eject_d, eject_n, busy, done, err;

   int n_chk  = 0;
   int n_fail = 0;

   change_dispense_ctrl #(.PARSE_LAT(3), .MAX_CHANGE(70)) dut (
      .clk(clk), .reset(reset), .start(start), .change(change), .money(money),
      .parse_en(parse_en), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt),
      .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
      .eject_ack(eject_ack), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int outs_word();
      return int'({money, parse_en, eject_q, eject_d, eject_n, busy, done, err});
   endfunction

   // One transaction. Ack is given on the (dly+1)-th cycle a request is seen;
   // stray holds ack high throughout; abort_d resets the DUT on the first eject_d.
   task automatic run_txn(input string nm, input int chg, input int q, input int d, input int n,
                          input int dly, input bit stray, input bit poke, input bit abort_d,
                          input int eq, input int ed, input int en,
                          input bit epen, input int edone, input bit eerr);
      int  nc[4];
      int  npen = 0, pen_cyc = -1, done_cyc = -1;
      int  v_multi = 0, v_gap = 0, v_hold = 0, v_order = 0;
      int  wcnt = 0, last = 0, prev = 0, cur;
      bit  acked = 0, aborted = 0;
      nc = '{0, 0, 0, 0};
      @(negedge clk);
      q_cnt = 4'(q); d_cnt = 4'(d); n_cnt = 4'(n);
      change = 7'(chg); start = 1'b1; eject_ack = stray;
      for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke && cyc == 10) begin start = 1'b1; change = 7'd5; end
         if (cyc == 1) begin
            chk({nm, ".busy_c1"}, int'(busy), 1);
            chk({nm, ".money_c1"}, int'(money), chg);
            chk({nm, ".err_c1"}, int'(err), epen ? 0 : 1);
         end
         if (parse_en) begin npen++; pen_cyc = cyc; end
         cur = eject_q ? 1 : eject_d ? 2 : eject_n ? 3 : 0;
         if (int'(eject_q) + int'(eject_d) + int'(eject_n) > 1) v_multi++;
         if (abort_d && cur == 2) begin aborted = 1; break; end
         if (stray) begin
            if (cur != 0) nc[cur]++;
         end else if (acked) begin
            if (cur != 0) v_gap++;
            acked = 0; eject_ack = 1'b0;
         end else if (cur != 0) begin
            if (wcnt > 0 && cur != prev) v_hold++;
            if (cur < last) v_order++;
            if (wcnt == dly) begin
               eject_ack = 1'b1; acked = 1; wcnt = 0; last = cur; nc[cur]++;
            end else wcnt++;
            prev = cur;
         end else if (wcnt > 0) begin
            v_hold++; wcnt = 0;
         end
         if (done) begin
            done_cyc = cyc;
            chk({nm, ".err_at_done"}, int'(err), int'(eerr));
         end
      end
      if (aborted) begin
         reset = 1'b1; eject_ack = 1'b0;
         @(negedge clk);
         chk({nm, ".outs_after_reset"}, outs_word(), 0);
         chk({nm, ".q_before_reset"}, nc[1], eq);
         reset = 1'b0;
         return;
      end
      eject_ack = 1'b0;
      chk({nm, ".done_cyc"}, done_cyc, edone);
      chk({nm, ".pen_cnt"}, npen, epen ? 1 : 0);
      chk({nm, ".pen_cyc"}, pen_cyc, epen ? 4 : -1);
      chk({nm, ".q_coins"}, nc[1], eq);
      chk({nm, ".d_coins"}, nc[2], ed);
      chk({nm, ".n_coins"}, nc[3], en);
      chk({nm, ".protocol_viol"}, v_multi + v_gap + v_hold + v_order, 0);
      @(negedge clk);
      chk({nm, ".done_pulse"}, int'(done), 0);
      chk({nm, ".busy_after"}, int'(busy), 0);
      chk({nm, ".err_after"}, int'(err), int'(eerr));
      chk({nm, ".money_kept"}, int'(money), chg);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; eject_ack = 1'b0; change = '0;
      q_cnt = '0; d_cnt = '0; n_cnt = '0;
      repeat (2) @(negedge clk);
      chk("reset.outs", outs_word(), 0);
      reset = 1'b0;
      //       name    chg  q  d  n  dly str pk ab  eq ed en pen done err
      run_txn("c65",    65, 2, 1, 1, 0,  0,  0, 0,  2, 1, 1, 1, 14,  0);
      run_txn("c0",      0, 0, 0, 0, 0,  1,  0, 0,  0, 0, 0, 1,  9,  0);
      run_txn("c37",    37, 0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1,  1);
      repeat (3) @(negedge clk);
      chk("c37.err_sticky", int'(err), 1);
      run_txn("c75",    75, 0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0,  1,  1);
      run_txn("c70",    70, 2, 2, 0, 5,  0,  1, 0,  2, 2, 0, 1, 35,  0);
      run_txn("c35rst", 35, 1, 1, 0, 0,  0,  0, 1,  1, 0, 0, 1,  0,  0);
      run_txn("c05",     5, 0, 0, 1, 0,  0,  0, 0,  0, 0, 1, 1, 10,  0);
      run_txn("blank",  30,10, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1,  6,  1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
